pc_fetch_ctrl: RTL

Fetch sequencer that owns the architectural PC register and drives the existing next-PC unit.
- Drives the next-PC unit's select (pc_sel) and extension control (ext_op), and takes its computed next_pc back.
- Runs the instruction-memory req/ack handshake and presents fetched instructions to decode via valid/ready.
- Handles halt and memory-timeout errors.
- Sits between the next-PC unit, instruction memory and decode.

---
 rtl/pc_fetch_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the architectural PC, steers the external next-PC unit,
// runs the imem req/ack handshake and hands instructions to decode.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    output logic [1:0]  pc_sel,
    output logic        ext_op,
    input  logic [31:0] next_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        instr_ready,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic        sext,
    input  logic        halt,
    output logic        fetch_err
);

    localparam int                CNT_W    = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        DELIVER = 3'd2,
        HALTED  = 3'd3,
        ERROR   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic               w_accept;
    logic [1:0]         w_pc_sel;
    logic               w_ext_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == REQ && imem_ack)
                r_instr <= imem_data;
            if (w_accept)
                r_pc <= next_pc;
            // Counter only runs while a request is outstanding; any other cycle re-arms it.
            if (r_state == REQ && !imem_ack)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else
                r_wait_cnt <= '0;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_pc_sel = 2'b00;
        w_ext_op = 1'b0;
        case (r_state)
            IDLE:    w_next = halt ? HALTED : REQ;
            REQ: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (imem_ack)
                    w_next = DELIVER;
                else if (r_wait_cnt == CNT_LAST)
                    w_next = ERROR;
            end
            DELIVER: begin
                if (instr_ready) begin
                    w_accept = 1'b1;
                    if (jump) begin
                        w_pc_sel = 2'b01;
                    end else if (branch_taken) begin
                        w_pc_sel = 2'b10;
                        w_ext_op = sext;
                    end
                    w_next = halt ? HALTED : REQ;
                end
            end
            HALTED:  if (!halt) w_next = REQ;
            ERROR:   w_next = ERROR;
            default: w_next = IDLE;
        endcase
    end

    assign pc          = r_pc;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign pc_sel      = w_pc_sel;
    assign ext_op      = w_ext_op;
    assign imem_req    = (r_state == REQ);
    assign instr_valid = (r_state == DELIVER);
    assign fetch_err   = (r_state == ERROR);

endmodule
